alu_issue_queue: RTL

//  Reservation station directly upstream of the ALU units. Buffers renamed ops from dispatch,

---
 rtl/alu_issue_queue_if.sv | 46 ++++
 rtl/alu_issue_queue.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/alu_issue_queue_if.sv
// Dispatch, CDB and issue bundle between the ALU issue queue and its neighbours.
// The queue side uses the slave modport; the environment (dispatch/CDB/ALUs) uses master.
interface alu_issue_queue_if #(
    parameter int unsigned NUM_ALU = 3,
    parameter int unsigned TAG_W   = 6
);
    logic               disp_valid;
    logic               disp_ready;
    logic [3:0]         disp_optype;
    logic [TAG_W-1:0]   disp_src1_tag;
    logic               disp_src1_rdy;
    logic [31:0]        disp_src1_data;
    logic [TAG_W-1:0]   disp_src2_tag;
    logic               disp_src2_rdy;
    logic [31:0]        disp_src2_data;
    logic [31:0]        disp_imm;
    logic [TAG_W-1:0]   disp_dst_tag;

    logic               cdb_valid;
    logic [TAG_W-1:0]   cdb_tag;
    logic [31:0]        cdb_data;

    logic [NUM_ALU-1:0] alu_free;
    logic [NUM_ALU-1:0] alu_number;
    logic [3:0]         optype;
    logic [31:0]        data_in_sr1;
    logic [31:0]        data_in_sr2;
    logic [31:0]        data_in_imm;
    logic [TAG_W-1:0]   iss_dst_tag;

    modport master (
        output disp_valid, disp_optype, disp_src1_tag, disp_src1_rdy, disp_src1_data,
               disp_src2_tag, disp_src2_rdy, disp_src2_data, disp_imm, disp_dst_tag,
               cdb_valid, cdb_tag, cdb_data, alu_free,
        input  disp_ready, alu_number, optype, data_in_sr1, data_in_sr2, data_in_imm,
               iss_dst_tag
    );

    modport slave (
        input  disp_valid, disp_optype, disp_src1_tag, disp_src1_rdy, disp_src1_data,
               disp_src2_tag, disp_src2_rdy, disp_src2_data, disp_imm, disp_dst_tag,
               cdb_valid, cdb_tag, cdb_data, alu_free,
        output disp_ready, alu_number, optype, data_in_sr1, data_in_sr2, data_in_imm,
               iss_dst_tag
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Reservation station feeding the ALUs: buffers dispatched ops, wakes sources from the CDB
// and issues the lowest-index ready op to a free ALU chosen round-robin.
module alu_issue_queue #(
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NUM_ALU = 3,
    parameter int unsigned TAG_W   = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    alu_issue_queue_if.slave         bus,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned OccW = IdxW + 1;
    localparam int unsigned RrW  = (NUM_ALU > 1) ? $clog2(NUM_ALU) : 1;

    logic [DEPTH-1:0] valid_q, rdy1_q, rdy2_q;
    logic [3:0]       op_q   [DEPTH];
    logic [TAG_W-1:0] tag1_q [DEPTH];
    logic [TAG_W-1:0] tag2_q [DEPTH];
    logic [TAG_W-1:0] dst_q  [DEPTH];
    logic [31:0]      data1_q[DEPTH];
    logic [31:0]      data2_q[DEPTH];
    logic [31:0]      imm_q  [DEPTH];

    logic [RrW-1:0]     rr_q, rr_d;
    logic [OccW-1:0]    occ_q;
    logic [NUM_ALU-1:0] alu_num_q, alu_sel;
    logic [3:0]         iss_op_q;
    logic [31:0]        iss_sr1_q, iss_sr2_q, iss_imm_q;
    logic [TAG_W-1:0]   iss_dst_q;

    logic            disp_ready, disp_fire, cdb_live, issue;
    logic            free_found, cand_found, alu_found;
    logic [IdxW-1:0] free_idx, cand_idx;
    logic [RrW-1:0]  alu_idx;
    logic [1:0]      use_src;
    logic            new_rdy1, new_rdy2, byp1, byp2;

    // Bit 0: src1 used, bit 1: src2 used. Unknown op codes carry no sources.
    function automatic logic [1:0] src_use(input logic [3:0] op);
        case (op)
            4'd1, 4'd5, 4'd9, 4'd10:       src_use = 2'b11;
            4'd2, 4'd4, 4'd6, 4'd7, 4'd8:  src_use = 2'b01;
            default:                       src_use = 2'b00;
        endcase
    endfunction

    assign disp_ready = occ_q < OccW'(DEPTH);
    assign disp_fire  = bus.disp_valid & disp_ready & ~flush;
    assign cdb_live   = bus.cdb_valid & (bus.cdb_tag != '0);
    assign use_src    = src_use(bus.disp_optype);
    assign byp1       = use_src[0] & ~bus.disp_src1_rdy & cdb_live &
                        (bus.cdb_tag == bus.disp_src1_tag);
    assign byp2       = use_src[1] & ~bus.disp_src2_rdy & cdb_live &
                        (bus.cdb_tag == bus.disp_src2_tag);
    assign new_rdy1   = ~use_src[0] | bus.disp_src1_rdy | byp1;
    assign new_rdy2   = ~use_src[1] | bus.disp_src2_rdy | byp2;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (!cand_found && valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                cand_found = 1'b1;
                cand_idx   = IdxW'(i);
            end
        end
    end

    // Round-robin: first pass scans from rr_q upward, second pass wraps to the low ALUs.
    always_comb begin
        alu_found = 1'b0;
        alu_idx   = '0;
        for (int a = 0; a < NUM_ALU; a++) begin
            if (!alu_found && a >= int'(rr_q) && bus.alu_free[a]) begin
                alu_found = 1'b1;
                alu_idx   = RrW'(a);
            end
        end
        for (int a = 0; a < NUM_ALU; a++) begin
            if (!alu_found && bus.alu_free[a]) begin
                alu_found = 1'b1;
                alu_idx   = RrW'(a);
            end
        end
        alu_sel = '0;
        for (int a = 0; a < NUM_ALU; a++) begin
            if (alu_idx == RrW'(a)) alu_sel[a] = 1'b1;
        end
        rr_d  = (alu_idx == RrW'(NUM_ALU - 1)) ? '0 : alu_idx + RrW'(1);
        issue = cand_found & alu_found;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q   <= '0;
            rdy1_q    <= '0;
            rdy2_q    <= '0;
            rr_q      <= '0;
            occ_q     <= '0;
            alu_num_q <= '0;
            iss_op_q  <= '0;
            iss_sr1_q <= '0;
            iss_sr2_q <= '0;
            iss_imm_q <= '0;
            iss_dst_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_live && !rdy1_q[i] && tag1_q[i] == bus.cdb_tag) begin
                    rdy1_q[i]  <= 1'b1;
                    data1_q[i] <= bus.cdb_data;
                end
                if (cdb_live && !rdy2_q[i] && tag2_q[i] == bus.cdb_tag) begin
                    rdy2_q[i]  <= 1'b1;
                    data2_q[i] <= bus.cdb_data;
                end
            end
            if (issue) begin
                valid_q[cand_idx] <= 1'b0;
                alu_num_q         <= alu_sel;
                iss_op_q          <= op_q[cand_idx];
                iss_sr1_q         <= data1_q[cand_idx];
                iss_sr2_q         <= data2_q[cand_idx];
                iss_imm_q         <= imm_q[cand_idx];
                iss_dst_q         <= dst_q[cand_idx];
                rr_q              <= rr_d;
            end else begin
                alu_num_q <= '0;
            end
            // Dispatch targets a free slot, so it never collides with the issuing entry.
            if (disp_fire) begin
                valid_q[free_idx] <= 1'b1;
                op_q[free_idx]    <= bus.disp_optype;
                tag1_q[free_idx]  <= bus.disp_src1_tag;
                tag2_q[free_idx]  <= bus.disp_src2_tag;
                rdy1_q[free_idx]  <= new_rdy1;
                rdy2_q[free_idx]  <= new_rdy2;
                data1_q[free_idx] <= byp1 ? bus.cdb_data : bus.disp_src1_data;
                data2_q[free_idx] <= byp2 ? bus.cdb_data : bus.disp_src2_data;
                imm_q[free_idx]   <= bus.disp_imm;
                dst_q[free_idx]   <= bus.disp_dst_tag;
            end
            occ_q <= occ_q + OccW'(disp_fire) - OccW'(issue);
        end
    end

    assign bus.disp_ready  = disp_ready;
    assign bus.alu_number  = alu_num_q;
    assign bus.optype      = iss_op_q;
    assign bus.data_in_sr1 = iss_sr1_q;
    assign bus.data_in_sr2 = iss_sr2_q;
    assign bus.data_in_imm = iss_imm_q;
    assign bus.iss_dst_tag = iss_dst_q;
    assign occupancy       = occ_q;

`ifndef SYNTHESIS
    occ_bounded_a: assert property (@(posedge clk) disable iff (rst)
        (occ_q <= OccW'(DEPTH)) && (32'(occ_q) == $countones(valid_q)));
`endif
endmodule
